// File: rtl/prism_aux_pkg.sv
// Shared constants for the PRISM auxiliary bank: register word indices,
// CTRL/IRQ field positions and the counter mode encoding.
package prism_aux_pkg;

  typedef logic [31:0] word_t;

  // Word indices on the register port
  localparam logic [3:0] ADDR_CTRL  = 4'd0;
  localparam logic [3:0] ADDR_SHIFT = 4'd1;
  localparam logic [3:0] ADDR_IRQ   = 4'd2;
  localparam int         CNT_BASE   = 4;

  // CTRL field positions
  localparam int CTRL_DIR_BIT   = 0;
  localparam int CTRL_SEL_LSB   = 4;
  localparam int CTRL_SEL_W     = 3;
  localparam int CTRL_MODE_LSB  = 8;
  localparam int CTRL_CHAIN_LSB = 16;

  // IRQ field positions
  localparam int IRQ_MASK_LSB = 16;

  // Counter mode encoding
  localparam logic MODE_DOWN = 1'b0;
  localparam logic MODE_UP   = 1'b1;

  // Each counter occupies two words: preload/compare, then count
  function automatic logic [3:0] preload_addr(input int k);
    return 4'(CNT_BASE + 2 * k);
  endfunction

  function automatic logic [3:0] count_addr(input int k);
    return 4'(CNT_BASE + 2 * k + 1);
  endfunction

endpackage

// File: rtl/prism_aux_bank_if.sv
// 32-bit register port between the TinyQV peripheral decode (master)
// and the auxiliary bank (slave). Read data is combinational.
interface prism_aux_bank_if;
  import prism_aux_pkg::*;

  logic [3:0] reg_addr;
  logic       reg_wr;
  word_t      reg_wdata;
  word_t      reg_rdata;

  modport master (
    output reg_addr,
    output reg_wr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wr,
    input  reg_wdata,
    output reg_rdata
  );

endinterface

// File: rtl/prism_aux_counter.sv
// One auxiliary counter: down-to-zero or up-to-compare, with its own
// preload/compare register, mode bit, terminal flag and rising-edge detect.
module prism_aux_counter
  import prism_aux_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             enable,
  input  logic             step,
  input  logic             load,
  input  logic             mode_wr,
  input  logic             mode_d,
  input  logic             pre_wr,
  input  logic [CNT_W-1:0] pre_d,
  output logic             mode,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] preload,
  output logic             term,
  output logic             term_rise
);

  logic term_prev;

  // Mode and preload/compare are plain register-port fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode    <= MODE_DOWN;
      preload <= '0;
    end else begin
      if (mode_wr) mode <= mode_d;
      if (pre_wr)  preload <= pre_d;
    end
  end

  // Count update; step together with load is a hold, down mode saturates at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!halt) begin
      if (step && !load) begin
        if (mode == MODE_UP)
          count <= count + CNT_W'(1);
        else if (count != '0)
          count <= count - CNT_W'(1);
      end else if (load && !step && enable) begin
        count <= (mode == MODE_UP) ? '0 : preload;
      end
    end
  end

  assign term = (mode == MODE_UP) ? (count == preload) : (count == '0);

  // Previous terminal state resets high so reset itself is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) term_prev <= 1'b1;
    else     term_prev <= term;
  end

  assign term_rise = term & ~term_prev;

endmodule

// File: rtl/prism_aux_bank.sv
// PRISM auxiliary bank: NUM_CNT counters, a selectable-input shifter,
// an output latch, maskable per-counter interrupts and a register port.
// Optional counter cascade is built when PRISM_AUX_CHAIN_EN is defined.
module prism_aux_bank
  import prism_aux_pkg::*;
#(
  parameter int NUM_CNT   = 2,
  parameter int CNT_W     = 24,
  parameter int SHIFT_W   = 8,
  parameter int COMM_IN_W = 4,
  parameter int LATCH_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic                 enable,
  input  logic [NUM_CNT-1:0]   cnt_step,
  input  logic [NUM_CNT-1:0]   cnt_load,
  output logic [NUM_CNT-1:0]   cnt_term,
  input  logic                 shift_en,
  input  logic [COMM_IN_W-1:0] comm_in,
  output logic                 shift_out,
  input  logic                 latch_en,
  input  logic [LATCH_W-1:0]   latch_d,
  output logic [LATCH_W-1:0]   latch_q,
  prism_aux_bank_if.slave      bus,
  output logic                 irq
);

  logic                    wr_ctrl, wr_shift, wr_irq;
  logic [NUM_CNT-1:0]      wr_pre;
  logic [NUM_CNT-1:0]      mode, term, term_rise, step_eff, chain;
  logic [NUM_CNT-1:0]      pending, mask;
  logic [CNT_W-1:0]        cnt_val [NUM_CNT];
  logic [CNT_W-1:0]        pre_val [NUM_CNT];
  logic                    shift_dir;
  logic [CTRL_SEL_W-1:0]   comm_sel;
  logic [SHIFT_W-1:0]      sreg;
  logic                    shift_in;
  word_t                   rdata;

  assign wr_ctrl  = bus.reg_wr && (bus.reg_addr == ADDR_CTRL);
  assign wr_shift = bus.reg_wr && (bus.reg_addr == ADDR_SHIFT);
  assign wr_irq   = bus.reg_wr && (bus.reg_addr == ADDR_IRQ);

  // Per-counter preload write strobes
  always_comb begin
    wr_pre = '0;
    for (int k = 0; k < NUM_CNT; k++)
      wr_pre[k] = bus.reg_wr && (bus.reg_addr == preload_addr(k));
  end

`ifdef PRISM_AUX_CHAIN_EN
  // Chain enables; the last counter has nothing to feed so its bit stays 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else if (wr_ctrl) begin
      for (int k = 0; k < NUM_CNT; k++)
        chain[k] <= (k < NUM_CNT - 1) ? bus.reg_wdata[CTRL_CHAIN_LSB + k] : 1'b0;
    end
  end

  // A terminal rising edge on counter k adds one step to counter k+1
  always_comb begin
    step_eff = cnt_step;
    for (int k = 1; k < NUM_CNT; k++)
      step_eff[k] = cnt_step[k] | (chain[k-1] & term_rise[k-1]);
  end
`else
  assign chain    = '0;
  assign step_eff = cnt_step;
`endif

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    prism_aux_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .halt      (halt),
      .enable    (enable),
      .step      (step_eff[k]),
      .load      (cnt_load[k]),
      .mode_wr   (wr_ctrl),
      .mode_d    (bus.reg_wdata[CTRL_MODE_LSB + k]),
      .pre_wr    (wr_pre[k]),
      .pre_d     (bus.reg_wdata[CNT_W-1:0]),
      .mode      (mode[k]),
      .count     (cnt_val[k]),
      .preload   (pre_val[k]),
      .term      (term[k]),
      .term_rise (term_rise[k])
    );
  end

  assign cnt_term = term;

  // Pending bits: a fresh terminal edge beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~(wr_irq ? bus.reg_wdata[NUM_CNT-1:0] : '0)) | term_rise;
      if (wr_irq) mask <= bus.reg_wdata[IRQ_MASK_LSB +: NUM_CNT];
    end
  end

  assign irq = |(pending & mask);

  // CTRL shifter fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_dir <= 1'b0;
      comm_sel  <= '0;
    end else if (wr_ctrl) begin
      shift_dir <= bus.reg_wdata[CTRL_DIR_BIT];
      comm_sel  <= bus.reg_wdata[CTRL_SEL_LSB +: CTRL_SEL_W];
    end
  end

  // Serial input select; out-of-range selections fall back to comm_in[0]
  always_comb begin
    shift_in = comm_in[0];
    for (int i = 0; i < COMM_IN_W; i++)
      if (comm_sel == CTRL_SEL_W'(i)) shift_in = comm_in[i];
  end

  // Shift register; a register write takes priority over a shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (wr_shift) begin
      sreg <= bus.reg_wdata[SHIFT_W-1:0];
    end else if (shift_en && !halt) begin
      if (shift_dir) sreg <= {shift_in, sreg[SHIFT_W-1:1]};
      else           sreg <= {sreg[SHIFT_W-2:0], shift_in};
    end
  end

  assign shift_out = shift_dir ? sreg[0] : sreg[SHIFT_W-1];

  // Output latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  latch_q <= '0;
    else if (latch_en && !halt) latch_q <= latch_d;
  end

  // Read mux; unmapped words and unused bits return 0
  always_comb begin
    rdata = '0;
    case (bus.reg_addr)
      ADDR_CTRL: begin
        rdata[CTRL_DIR_BIT]                 = shift_dir;
        rdata[CTRL_SEL_LSB +: CTRL_SEL_W]   = comm_sel;
        rdata[CTRL_MODE_LSB +: NUM_CNT]     = mode;
        rdata[CTRL_CHAIN_LSB +: NUM_CNT]    = chain;
      end
      ADDR_SHIFT: rdata[SHIFT_W-1:0] = sreg;
      ADDR_IRQ: begin
        rdata[NUM_CNT-1:0]              = pending;
        rdata[IRQ_MASK_LSB +: NUM_CNT]  = mask;
      end
      default: begin
        for (int k = 0; k < NUM_CNT; k++) begin
          if (bus.reg_addr == preload_addr(k)) rdata[CNT_W-1:0] = pre_val[k];
          if (bus.reg_addr == count_addr(k))   rdata[CNT_W-1:0] = cnt_val[k];
        end
      end
    endcase
  end

  assign bus.reg_rdata = rdata;

endmodule

// File: tb/tb_prism_aux_bank.sv
// Self-checking bench for prism_aux_bank with a cycle-level reference model.
module tb_prism_aux_bank;

  localparam int N   = 2;
  localparam int CW  = 24;
  localparam int SW  = 8;
  localparam int CIW = 4;
  localparam int LW  = 4;
  localparam int unsigned     SMASK = (32'd1 << SW) - 1;
  localparam longint unsigned CMASK = (64'd1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           halt, enable, shift_en, latch_en;
  logic [N-1:0]   cnt_step, cnt_load, cnt_term, cnt_term4;
  logic [CIW-1:0] comm_in;
  logic [LW-1:0]  latch_d, latch_q, latch_q4;
  logic           shift_out, shift_out4, irq, irq4;

  prism_aux_bank_if bus ();
  prism_aux_bank_if bus4 ();

  always #5 clk = ~clk;

  prism_aux_bank #(.NUM_CNT(N), .CNT_W(CW), .SHIFT_W(SW), .COMM_IN_W(CIW), .LATCH_W(LW)) dut (
    .clk(clk), .rst(rst), .halt(halt), .enable(enable),
    .cnt_step(cnt_step), .cnt_load(cnt_load), .cnt_term(cnt_term),
    .shift_en(shift_en), .comm_in(comm_in), .shift_out(shift_out),
    .latch_en(latch_en), .latch_d(latch_d), .latch_q(latch_q),
    .bus(bus.slave), .irq(irq)
  );

  prism_aux_bank #(.NUM_CNT(N), .CNT_W(4), .SHIFT_W(SW), .COMM_IN_W(CIW), .LATCH_W(LW)) dut4 (
    .clk(clk), .rst(rst), .halt(halt), .enable(enable),
    .cnt_step(cnt_step), .cnt_load(cnt_load), .cnt_term(cnt_term4),
    .shift_en(shift_en), .comm_in(comm_in), .shift_out(shift_out4),
    .latch_en(latch_en), .latch_d(latch_d), .latch_q(latch_q4),
    .bus(bus4.slave), .irq(irq4)
  );

  // Reference model state
  longint unsigned m_cnt [N];
  longint unsigned m_pre [N];
  bit [N-1:0]      m_mode, m_pend, m_mask, m_tprev, m_chain;
  int unsigned     m_sreg, m_latch;
  bit              m_dir;
  int              m_sel;

  int checks = 0;
  int failures = 0;

  function automatic bit m_term(input int k);
    return m_mode[k] ? (m_cnt[k] == m_pre[k]) : (m_cnt[k] == 0);
  endfunction

  function automatic logic [N-1:0] m_terms();
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) t[k] = m_term(k);
    return t;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) begin
      r[0]   = m_dir;
      r[6:4] = 3'(m_sel);
      for (int k = 0; k < N; k++) begin
        r[8 + k]  = m_mode[k];
        r[16 + k] = m_chain[k];
      end
    end else if (a == 1) begin
      r = m_sreg;
    end else if (a == 2) begin
      for (int k = 0; k < N; k++) begin
        r[k]      = m_pend[k];
        r[16 + k] = m_mask[k];
      end
    end else if (a >= 4 && a < 4 + 2 * N) begin
      r = ((a % 2) == 0) ? 32'(m_pre[(a - 4) / 2]) : 32'(m_cnt[(a - 4) / 2]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0;
      m_pre[k] = 0;
    end
    m_mode = '0; m_pend = '0; m_mask = '0; m_chain = '0; m_tprev = '1;
    m_sreg = 0; m_latch = 0; m_dir = 0; m_sel = 0;
  endtask

  task automatic idle();
    halt = 0; enable = 0; shift_en = 0; latch_en = 0;
    cnt_step = '0; cnt_load = '0; comm_in = '0; latch_d = '0;
    bus.reg_wr = 0; bus.reg_addr = '0; bus.reg_wdata = '0;
    bus4.reg_wr = 0; bus4.reg_addr = '0; bus4.reg_wdata = '0;
  endtask

  // One clock: predict next state from current inputs, then advance
  task automatic tick();
    logic [N-1:0]    t, rise, st, np, nmask, nchain, clr, nmode;
    longint unsigned nc [N];
    longint unsigned npre [N];
    int unsigned     ns, nl;
    bit              nd, sin;
    int              nsel, a;
    logic [31:0]     w;
    t = m_terms();
    rise = t & ~m_tprev;
    st = cnt_step;
`ifdef PRISM_AUX_CHAIN_EN
    for (int k = 1; k < N; k++) if (m_chain[k-1] && rise[k-1]) st[k] = 1'b1;
`endif
    nmode = m_mode;
    for (int k = 0; k < N; k++) begin
      nc[k] = m_cnt[k];
      npre[k] = m_pre[k];
      if (!halt) begin
        if (st[k] && !cnt_load[k])
          nc[k] = m_mode[k] ? (m_cnt[k] + 1) % (64'd1 << CW) : (m_cnt[k] == 0 ? 0 : m_cnt[k] - 1);
        else if (cnt_load[k] && !st[k] && enable)
          nc[k] = m_mode[k] ? 0 : m_pre[k];
      end
    end
    sin = (m_sel < CIW) ? comm_in[m_sel] : comm_in[0];
    ns = m_sreg;
    if (shift_en && !halt)
      ns = m_dir ? ((m_sreg >> 1) | (32'(sin) << (SW - 1))) : (((m_sreg << 1) | 32'(sin)) & SMASK);
    nl = m_latch;
    if (latch_en && !halt) nl = 32'(latch_d);
    nd = m_dir; nsel = m_sel; nmask = m_mask; nchain = m_chain; clr = '0;
    if (bus.reg_wr) begin
      w = bus.reg_wdata;
      a = int'(bus.reg_addr);
      if (a == 0) begin
        nd = w[0];
        nsel = int'(w[6:4]);
        for (int k = 0; k < N; k++) nmode[k] = w[8 + k];
`ifdef PRISM_AUX_CHAIN_EN
        for (int k = 0; k < N - 1; k++) nchain[k] = w[16 + k];
`endif
      end else if (a == 1) begin
        ns = w & SMASK;
      end else if (a == 2) begin
        clr = w[N-1:0];
        for (int k = 0; k < N; k++) nmask[k] = w[16 + k];
      end else begin
        for (int k = 0; k < N; k++) if (a == 4 + 2 * k) npre[k] = longint'(w) & CMASK;
      end
    end
    np = (m_pend & ~clr) | rise;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = nc[k];
      m_pre[k] = npre[k];
    end
    m_mode = nmode; m_sreg = ns; m_latch = nl; m_dir = nd; m_sel = nsel;
    m_mask = nmask; m_chain = nchain; m_pend = np; m_tprev = t;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.reg_addr = 4'(a);
    bus.reg_wdata = d;
    bus.reg_wr = 1;
    tick();
    bus.reg_wr = 0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    bus.reg_addr = 4'(a);
    #1;
    d = bus.reg_rdata;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst = 1;
    #2;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle();
    rst = 1;
    #3;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      rd(a, d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_word%0d got=%h exp=%h", a, d, 32'h0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++;
    if (cnt_term !== 2'b11) begin failures++; $display("FAIL reset_term got=%b exp=11", cnt_term); end
    checks++;
    if (latch_q !== 4'h0) begin failures++; $display("FAIL reset_latch got=%h exp=0", latch_q); end
    @(negedge clk);
    rst = 0;
    wr(4, 32'd9);
    cnt_load[0] = 1; enable = 1;
    tick();
    cnt_load = '0; cnt_step[0] = 1;
    tick();
    tick();
    cnt_step = '0;
    rd(5, d);
    checks++;
    if (d !== 32'd7) begin failures++; $display("FAIL midrun_count got=%0d exp=7", d); end
    rst = 1;
    #1;
    rd(5, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL async_rst_count got=%0d exp=0", d); end
    rd(4, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL async_rst_preload got=%0d exp=0", d); end
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_down();
    logic [31:0] d;
    int exp_cnt [7] = '{4, 3, 2, 1, 0, 0, 0};
    int rises;
    logic prev_t;
    do_reset();
    wr(4, 32'd5);
    cnt_load[0] = 1; enable = 1;
    tick();
    cnt_load = '0;
    rd(5, d);
    checks++;
    if (d !== 32'd5) begin failures++; $display("FAIL down_load got=%0d exp=5", d); end
    prev_t = cnt_term[0];
    rises = 0;
    cnt_step[0] = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (cnt_term[0] && !prev_t) rises++;
      prev_t = cnt_term[0];
      rd(5, d);
      checks++;
      if (d !== 32'(exp_cnt[i]) || d !== model_read(5)) begin
        failures++;
        $display("FAIL down_count step%0d got=%0d exp=%0d", i, d, exp_cnt[i]);
      end
    end
    cnt_step = '0;
    checks++;
    if (rises != 1) begin failures++; $display("FAIL down_term_rises got=%0d exp=1", rises); end
    rd(2, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL down_pending got=%h exp=1", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL down_irq_masked got=%b exp=0", irq); end
    wr(2, 32'h0001_0000);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL down_irq_unmasked got=%b exp=1", irq); end
    wr(2, 32'h0001_0001);
    rd(2, d);
    checks++;
    if (d !== 32'h0001_0000 || d !== model_read(2)) begin
      failures++;
      $display("FAIL down_w1c got=%h exp=%h", d, 32'h0001_0000);
    end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL down_irq_cleared got=%b exp=0", irq); end
  endtask

  task automatic test_up();
    logic [31:0] d;
    do_reset();
    wr(0, 32'h0000_0200);
    wr(6, 32'd3);
    cnt_step[1] = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      rd(7, d);
      checks++;
      if (d !== 32'(i)) begin failures++; $display("FAIL up_count step%0d got=%0d exp=%0d", i, d, i); end
      checks++;
      if (cnt_term[1] !== (i == 3)) begin
        failures++;
        $display("FAIL up_term step%0d got=%b exp=%b", i, cnt_term[1], (i == 3));
      end
    end
    cnt_step = '0;
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    do_reset();
    bus4.reg_addr = 4'd0; bus4.reg_wdata = 32'h0000_0100; bus4.reg_wr = 1;
    tick();
    bus4.reg_wr = 0;
    bus4.reg_addr = 4'd5;
    cnt_step[0] = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      d = bus4.reg_rdata;
      checks++;
      if (d !== 32'(i % 16)) begin failures++; $display("FAIL wrap_count step%0d got=%0d exp=%0d", i, d, i % 16); end
    end
    cnt_step = '0;
  endtask

  task automatic test_shift();
    logic [31:0] d;
    do_reset();
    wr(1, 32'hA5);
    wr(0, 32'h20);
    comm_in = 4'b0100; shift_en = 1;
    tick();
    shift_en = 0;
    rd(1, d);
    checks++;
    if (d !== 32'h4B) begin failures++; $display("FAIL shift_left got=%h exp=4b", d); end
    checks++;
    if (shift_out !== 1'b0) begin failures++; $display("FAIL shift_out_left got=%b exp=0", shift_out); end
    wr(0, 32'h21);
    comm_in = 4'b0000; shift_en = 1;
    tick();
    shift_en = 0;
    rd(1, d);
    checks++;
    if (d !== 32'h25) begin failures++; $display("FAIL shift_right got=%h exp=25", d); end
    checks++;
    if (shift_out !== 1'b1) begin failures++; $display("FAIL shift_out_right got=%b exp=1", shift_out); end
    shift_en = 1; comm_in = 4'b1111;
    wr(1, 32'h3C);
    shift_en = 0;
    rd(1, d);
    checks++;
    if (d !== 32'h3C) begin failures++; $display("FAIL shift_write_wins got=%h exp=3c", d); end
    wr(0, 32'h50);
    comm_in = 4'b0001; shift_en = 1;
    tick();
    shift_en = 0;
    rd(1, d);
    checks++;
    if (d !== 32'h79 || d !== model_read(1)) begin failures++; $display("FAIL shift_sel_fallback got=%h exp=79", d); end
  endtask

  task automatic test_halt();
    logic [31:0] d;
    do_reset();
    wr(4, 32'd10);
    cnt_load[0] = 1; enable = 1;
    tick();
    cnt_load = '0;
    wr(1, 32'h5A);
    latch_en = 1; latch_d = 4'h3;
    tick();
    latch_en = 0;
    checks++;
    if (latch_q !== 4'h3) begin failures++; $display("FAIL latch_capture got=%h exp=3", latch_q); end
    halt = 1; cnt_step = '1; shift_en = 1; latch_en = 1; latch_d = 4'hC; comm_in = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      rd(5, d);
      checks++;
      if (d !== 32'd10) begin failures++; $display("FAIL halt_count cyc%0d got=%0d exp=10", i, d); end
      rd(1, d);
      checks++;
      if (d !== 32'h5A) begin failures++; $display("FAIL halt_shift cyc%0d got=%h exp=5a", i, d); end
      checks++;
      if (latch_q !== 4'h3) begin failures++; $display("FAIL halt_latch cyc%0d got=%h exp=3", i, latch_q); end
    end
    wr(6, 32'd7);
    rd(6, d);
    checks++;
    if (d !== 32'd7) begin failures++; $display("FAIL halt_reg_write got=%0d exp=7", d); end
    idle();
  endtask

  task automatic test_chain();
    logic [31:0] d;
    int exp1;
`ifdef PRISM_AUX_CHAIN_EN
    exp1 = 1;
`else
    exp1 = 0;
`endif
    do_reset();
    wr(0, 32'h0001_0300);
    wr(4, 32'd1);
    cnt_step[0] = 1;
    for (int i = 0; i < 4; i++) tick();
    cnt_step = '0;
    tick();
    rd(7, d);
    checks++;
    if (d !== 32'(exp1) || d !== model_read(7)) begin failures++; $display("FAIL chain_count1 got=%0d exp=%0d", d, exp1); end
    rd(5, d);
    checks++;
    if (d !== 32'd4) begin failures++; $display("FAIL chain_count0 got=%0d exp=4", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    int a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      halt = ($urandom_range(9) == 0);
      enable = 1'($urandom);
      cnt_step = N'($urandom);
      cnt_load = N'($urandom_range(3) == 0 ? $urandom : 0);
      shift_en = 1'($urandom);
      comm_in = CIW'($urandom);
      latch_en = 1'($urandom);
      latch_d = LW'($urandom);
      bus.reg_wr = ($urandom_range(3) == 0);
      bus.reg_addr = 4'($urandom);
      bus.reg_wdata = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(6));
      tick();
      bus.reg_wr = 0;
      checks++;
      if (cnt_term !== m_terms()) begin
        failures++;
        if (failures < 20) $display("FAIL rand_term cyc%0d got=%b exp=%b", i, cnt_term, m_terms());
      end
      checks++;
      if (irq !== |(m_pend & m_mask)) begin
        failures++;
        if (failures < 20) $display("FAIL rand_irq cyc%0d got=%b exp=%b", i, irq, |(m_pend & m_mask));
      end
      checks++;
      if (shift_out !== (m_dir ? m_sreg[0] : m_sreg[SW-1])) begin
        failures++;
        if (failures < 20) $display("FAIL rand_shift_out cyc%0d got=%b", i, shift_out);
      end
      checks++;
      if (latch_q !== LW'(m_latch)) begin
        failures++;
        if (failures < 20) $display("FAIL rand_latch cyc%0d got=%h exp=%h", i, latch_q, LW'(m_latch));
      end
      a = $urandom_range(15);
      rd(a, d);
      e = model_read(a);
      checks++;
      if (d !== e) begin
        failures++;
        if (failures < 20) $display("FAIL rand_read cyc%0d word%0d got=%h exp=%h", i, a, d, e);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    test_reset();
    test_down();
    test_up();
    test_wrap();
    test_shift();
    test_halt();
    test_chain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
